// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle controller: fill, wash, drain, rinse passes and spin,
// with pause/resume, abort-through-drain, fill/drain watchdogs and coded errors.
module wash_cycle_sequencer #(
  parameter int TIMER_W       = 8,
  parameter int WD_W          = 6,
  parameter int FILL_TIMEOUT  = 40,
  parameter int DRAIN_TIMEOUT = 30,
  parameter int RINSE_TIME    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [1:0]         cycle_select,
  input  logic [1:0]         water_level_select,
  input  logic               lid_closed,
  input  logic               load_balanced,
  input  logic               water_full,
  input  logic               water_empty,
  output logic               motor_on,
  output logic               motor_fast,
  output logic               water_pump_on,
  output logic               drain_on,
  output logic               door_locked,
  output logic               alarm,
  output logic [2:0]         error_code,
  output logic               end_of_cycle_alarm,
  output logic [3:0]         state_out,
  output logic [TIMER_W-1:0] timer_output,
  output logic [1:0]         rinse_left
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FILL   = 4'd1,
    WASH   = 4'd2,
    DRAIN  = 4'd3,
    RINSE  = 4'd4,
    SPIN   = 4'd5,
    DONE   = 4'd6,
    PAUSED = 4'd7,
    ERROR  = 4'd8
  } state_t;

  state_t             state_q, state_d, saved_q, saved_d;
  logic [TIMER_W-1:0] timer_q, timer_d, wash_load, spin_load;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [1:0]         rinse_q, rinse_d, rinse_load;
  logic [2:0]         err_q, err_d;
  logic               wash_done_q, wash_done_d, aborting_q, aborting_d;
  logic               timer_exp, fill_to, drain_to;
  logic               motor_on_q, motor_on_d, motor_fast_q, motor_fast_d;
  logic               pump_q, pump_d, drain_q, drain_d, lock_q, lock_d;
  logic               alarm_q, alarm_d, eoc_q, eoc_d;

  always_comb begin
    case (cycle_select)
      2'd0:    begin wash_load = TIMER_W'(5);  rinse_load = 2'd1; end
      2'd1:    begin wash_load = TIMER_W'(10); rinse_load = 2'd2; end
      2'd2:    begin wash_load = TIMER_W'(15); rinse_load = 2'd3; end
      default: begin wash_load = TIMER_W'(8);  rinse_load = 2'd2; end
    endcase
    case (water_level_select)
      2'd0:    spin_load = TIMER_W'(3);
      2'd1:    spin_load = TIMER_W'(5);
      default: spin_load = TIMER_W'(7);
    endcase
  end

  assign timer_exp = tick && (timer_q == TIMER_W'(1));
  assign fill_to   = tick && (wd_q == WD_W'(FILL_TIMEOUT - 1));
  assign drain_to  = tick && (wd_q == WD_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      saved_q      <= IDLE;
      timer_q      <= '0;
      wd_q         <= '0;
      rinse_q      <= '0;
      err_q        <= '0;
      wash_done_q  <= 1'b0;
      aborting_q   <= 1'b0;
      motor_on_q   <= 1'b0;
      motor_fast_q <= 1'b0;
      pump_q       <= 1'b0;
      drain_q      <= 1'b0;
      lock_q       <= 1'b0;
      alarm_q      <= 1'b0;
      eoc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      timer_q      <= timer_d;
      wd_q         <= wd_d;
      rinse_q      <= rinse_d;
      err_q        <= err_d;
      wash_done_q  <= wash_done_d;
      aborting_q   <= aborting_d;
      motor_on_q   <= motor_on_d;
      motor_fast_q <= motor_fast_d;
      pump_q       <= pump_d;
      drain_q      <= drain_d;
      lock_q       <= lock_d;
      alarm_q      <= alarm_d;
      eoc_q        <= eoc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    err_d       = err_q;
    wash_done_d = wash_done_q;
    aborting_d  = aborting_q;
    rinse_d     = rinse_q;
    case (state_q)
      IDLE: if (start) begin
        if (!lid_closed)         begin state_d = ERROR; err_d = 3'd1; end
        else if (!load_balanced) begin state_d = ERROR; err_d = 3'd2; end
        else begin state_d = FILL; rinse_d = rinse_load; wash_done_d = 1'b0; end
      end
      FILL: begin
        if (!lid_closed)     begin state_d = ERROR; err_d = 3'd1; end
        else if (fill_to)    begin state_d = ERROR; err_d = 3'd3; end
        else if (abort)      begin state_d = DRAIN; aborting_d = 1'b1; end
        else if (water_full) state_d = wash_done_q ? RINSE : WASH;
      end
      WASH, RINSE, SPIN: begin
        if (!lid_closed) begin state_d = ERROR; err_d = 3'd1; end
        else if (state_q == SPIN && !load_balanced) begin state_d = ERROR; err_d = 3'd2; end
        else if (abort) begin state_d = DRAIN; aborting_d = 1'b1; end
        else if (pause) begin state_d = PAUSED; saved_d = state_q; end
        else if (timer_exp) begin
          state_d = (state_q == SPIN) ? DONE : DRAIN;
          if (state_q == WASH) wash_done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (!lid_closed)   begin state_d = ERROR; err_d = 3'd1; end
        else if (drain_to) begin state_d = ERROR; err_d = 3'd4; end
        else if (water_empty) begin
          if (aborting_q)          begin state_d = IDLE; aborting_d = 1'b0; end
          else if (rinse_q != '0) state_d = FILL;
          else                     state_d = SPIN;
        end
      end
      DONE:   state_d = IDLE;
      PAUSED: begin
        if (abort)                       begin state_d = DRAIN; aborting_d = 1'b1; end
        else if (!pause && lid_closed) state_d = saved_q;
      end
      ERROR: if (start && water_empty) begin
        state_d    = IDLE;
        err_d      = '0;
        aborting_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Resuming from PAUSED keeps the frozen countdown and does not consume a rinse pass.
    timer_d = '0;
    wd_d    = '0;
    if (state_d == state_q) begin
      wd_d = (tick && (state_q == FILL || state_q == DRAIN)) ? wd_q + 1'b1 : wd_q;
      if (state_q == WASH || state_q == RINSE || state_q == SPIN)
        timer_d = (tick && timer_q != '0) ? timer_q - 1'b1 : timer_q;
      else if (state_q == PAUSED)
        timer_d = timer_q;
    end else begin
      case (state_d)
        WASH:   timer_d = (state_q == PAUSED) ? timer_q : wash_load;
        SPIN:   timer_d = (state_q == PAUSED) ? timer_q : spin_load;
        PAUSED: timer_d = timer_q;
        RINSE: begin
          if (state_q == PAUSED) timer_d = timer_q;
          else begin
            timer_d = TIMER_W'(RINSE_TIME);
            if (rinse_q != '0) rinse_d = rinse_q - 1'b1;
          end
        end
        default: timer_d = '0;
      endcase
    end
  end

  always_comb begin
    motor_on_d   = state_d inside {WASH, RINSE, SPIN};
    motor_fast_d = (state_d == SPIN);
    pump_d       = (state_d == FILL);
    drain_d      = (state_d inside {DRAIN, SPIN}) || (state_d == ERROR && !water_empty);
    lock_d       = state_d inside {FILL, WASH, DRAIN, RINSE, SPIN, PAUSED};
    alarm_d      = (state_d == ERROR);
    eoc_d        = (state_d == DONE);
  end

  assign motor_on           = motor_on_q;
  assign motor_fast         = motor_fast_q;
  assign water_pump_on      = pump_q;
  assign drain_on           = drain_q;
  assign door_locked        = lock_q;
  assign alarm              = alarm_q;
  assign error_code         = err_q;
  assign end_of_cycle_alarm = eoc_q;
  assign state_out          = state_q;
  assign timer_output       = timer_q;
  assign rinse_left         = rinse_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: start-condition vector table, directed cycle
// scenarios and a randomized run, all compared against a phase-level model.
module tb_wash_cycle_sequencer;
  localparam int FILL_TO  = 40;
  localparam int DRAIN_TO = 30;
  localparam int RT       = 4;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, abort;
  logic [1:0] cycle_select, water_level_select;
  logic       lid_closed, load_balanced, water_full, water_empty;
  logic       motor_on, motor_fast, water_pump_on, drain_on, door_locked, alarm;
  logic [2:0] error_code;
  logic       end_of_cycle_alarm;
  logic [3:0] state_out;
  logic [7:0] timer_output;
  logic [1:0] rinse_left;

  wash_cycle_sequencer #(
    .TIMER_W(8), .WD_W(6), .FILL_TIMEOUT(FILL_TO), .DRAIN_TIMEOUT(DRAIN_TO), .RINSE_TIME(RT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .cycle_select(cycle_select), .water_level_select(water_level_select),
    .lid_closed(lid_closed), .load_balanced(load_balanced),
    .water_full(water_full), .water_empty(water_empty),
    .motor_on(motor_on), .motor_fast(motor_fast), .water_pump_on(water_pump_on),
    .drain_on(drain_on), .door_locked(door_locked), .alarm(alarm), .error_code(error_code),
    .end_of_cycle_alarm(end_of_cycle_alarm), .state_out(state_out),
    .timer_output(timer_output), .rinse_left(rinse_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  int eoc_cnt = 0;
  int last_st = 0;
  int trace[$];
  int wash_loads[$];
  int rinse_vals[$];

  int wash_min[4]  = '{5, 10, 15, 8};
  int spin_min[4]  = '{3, 5, 7, 7};
  int rinse_cnt[4] = '{1, 2, 3, 2};

  // Model: phase identity, ticks elapsed in the phase and the phase length.
  int m_st, m_saved, m_el, m_dur, m_rinse, m_err;
  bit m_washed, m_ab, m_drain_err;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cycle_no, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_saved = 0; m_el = 0; m_dur = 0; m_rinse = 0; m_err = 0;
    m_washed = 0; m_ab = 0; m_drain_err = 0;
  endtask

  task automatic model_step();
    int  nx;
    bit  resume;
    bit  expire;
    nx = m_st;
    resume = 0;
    expire = tick && (m_el + 1 == m_dur);
    case (m_st)
      0: if (start) begin
           if (!lid_closed)         begin nx = 8; m_err = 1; end
           else if (!load_balanced) begin nx = 8; m_err = 2; end
           else begin nx = 1; m_rinse = rinse_cnt[cycle_select]; m_washed = 0; end
         end
      1: if (!lid_closed) begin nx = 8; m_err = 1; end
         else if (tick && m_el + 1 == FILL_TO) begin nx = 8; m_err = 3; end
         else if (abort) begin nx = 3; m_ab = 1; end
         else if (water_full) nx = m_washed ? 4 : 2;
      2, 4, 5:
         if (!lid_closed) begin nx = 8; m_err = 1; end
         else if (m_st == 5 && !load_balanced) begin nx = 8; m_err = 2; end
         else if (abort) begin nx = 3; m_ab = 1; end
         else if (pause) begin nx = 7; m_saved = m_st; end
         else if (expire) begin
           nx = (m_st == 5) ? 6 : 3;
           if (m_st == 2) m_washed = 1;
         end
      3: if (!lid_closed) begin nx = 8; m_err = 1; end
         else if (tick && m_el + 1 == DRAIN_TO) begin nx = 8; m_err = 4; end
         else if (water_empty) nx = m_ab ? 0 : (m_rinse > 0 ? 1 : 5);
      6: nx = 0;
      7: if (abort) begin nx = 3; m_ab = 1; end
         else if (!pause && lid_closed) begin nx = m_saved; resume = 1; end
      8: if (start && water_empty) begin nx = 0; m_err = 0; end
      default: nx = 0;
    endcase
    if (nx == m_st) begin
      if (tick && nx >= 1 && nx <= 5) m_el++;
    end else if (!(nx == 7 || resume)) begin
      m_el = 0;
      case (nx)
        2: m_dur = wash_min[cycle_select];
        4: begin m_dur = RT; if (m_rinse > 0) m_rinse--; end
        5: m_dur = spin_min[water_level_select];
        default: m_dur = 0;
      endcase
    end
    if (nx == 0) m_ab = 0;
    m_drain_err = (nx == 8) && !water_empty;
    m_st = nx;
  endtask

  function automatic logic [23:0] exp_vec();
    int t;
    t = (m_st == 2 || m_st == 4 || m_st == 5 || m_st == 7) ? m_dur - m_el : 0;
    return {4'(m_st), 8'(t), 2'(m_rinse), 3'(m_err),
            1'(m_st == 2 || m_st == 4 || m_st == 5), 1'(m_st == 5), 1'(m_st == 1),
            1'(m_st == 3 || m_st == 5 || m_drain_err),
            1'(m_st >= 1 && m_st <= 5 || m_st == 7), 1'(m_st == 8), 1'(m_st == 6)};
  endfunction

  function automatic logic [23:0] act_vec();
    return {state_out, timer_output, rinse_left, error_code, motor_on, motor_fast,
            water_pump_on, drain_on, door_locked, alarm, end_of_cycle_alarm};
  endfunction

  task automatic cyc();
    logic [23:0] a, e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle_no++;
    a = act_vec();
    e = exp_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs (cycle %0d): got %h expected %h", cycle_no, a, e);
    end
    if (end_of_cycle_alarm) eoc_cnt++;
    if (int'(state_out) != last_st) begin
      trace.push_back(int'(state_out));
      if (state_out == 4'd2) wash_loads.push_back(int'(timer_output));
      if (state_out == 4'd4) rinse_vals.push_back(int'(rinse_left));
    end
    last_st = int'(state_out);
  endtask

  task automatic idle_inputs();
    tick = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cycle_select = 2'd0; water_level_select = 2'd0;
    lid_closed = 1'b1; load_balanced = 1'b1; water_full = 1'b1; water_empty = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_st = 0;
  endtask

  task automatic begin_cycle(input logic [1:0] cs, input logic [1:0] wl);
    idle_inputs();
    cycle_select = cs;
    water_level_select = wl;
    trace.delete(); wash_loads.delete(); rinse_vals.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget && int'(state_out) != s; i++) cyc();
    check(name, int'(state_out), s);
  endtask

  task automatic check_trace(input string name, input int exp_q[$]);
    check({name, "_len"}, trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++) check(name, trace[i], exp_q[i]);
  endtask

  typedef struct {
    logic       start, lid, bal;
    logic [1:0] cs;
    int         exp_state, exp_err, exp_rinse;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   n, e0;
    vecs[0] = '{1'b0, 1'b1, 1'b1, 2'd0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd0, 8, 1, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'd1, 8, 1, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd2, 8, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 2'd0, 1, 0, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 2'd1, 1, 0, 2};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd2, 1, 0, 3};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'd3, 1, 0, 2};

    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check("reset_outputs", int'(act_vec()), 0);
    do_reset();

    foreach (vecs[i]) begin
      do_reset();
      idle_inputs();
      start = vecs[i].start; lid_closed = vecs[i].lid;
      load_balanced = vecs[i].bal; cycle_select = vecs[i].cs;
      cyc();
      check($sformatf("vec%0d_state", i), int'(state_out), vecs[i].exp_state);
      check($sformatf("vec%0d_err", i), int'(error_code), vecs[i].exp_err);
      check($sformatf("vec%0d_rinse", i), int'(rinse_left), vecs[i].exp_rinse);
    end

    // Quick cycle, low level, instant sensors.
    do_reset();
    e0 = eoc_cnt;
    begin_cycle(2'd0, 2'd0);
    wait_state(0, 100, "quick_back_to_idle");
    check_trace("quick_trace", '{1, 2, 3, 1, 4, 3, 5, 6, 0});
    check("quick_wash_load", wash_loads.size() > 0 ? wash_loads[0] : -1, 5);
    check("quick_eoc_pulses", eoc_cnt - e0, 1);
    check("quick_door_unlocked", int'(door_locked), 0);

    // Heavy cycle: three rinse passes.
    begin_cycle(2'd2, 2'd2);
    check("heavy_rinse_load", int'(rinse_left), 3);
    wait_state(0, 200, "heavy_back_to_idle");
    check_trace("heavy_trace", '{1, 2, 3, 1, 4, 3, 1, 4, 3, 1, 4, 3, 5, 6, 0});
    check("heavy_wash_load", wash_loads.size() > 0 ? wash_loads[0] : -1, 15);
    check("heavy_rinse_seq_len", rinse_vals.size(), 3);
    for (int i = 0; i < 3 && i < rinse_vals.size(); i++) check("heavy_rinse_seq", rinse_vals[i], 2 - i);

    // Pause in WASH at 6, then lid opens mid-RINSE.
    begin_cycle(2'd1, 2'd1);
    for (int i = 0; i < 40 && !(state_out == 4'd2 && timer_output == 8'd6); i++) cyc();
    check("pause_reach_6", int'(timer_output), 6);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("paused_state", int'(state_out), 7);
    check("paused_timer", int'(timer_output), 6);
    check("paused_motor", int'(motor_on), 0);
    pause = 1'b0;
    cyc();
    check("resume_state", int'(state_out), 2);
    check("resume_timer", int'(timer_output), 6);
    wait_state(4, 60, "reach_rinse");
    lid_closed = 1'b0; water_empty = 1'b0;
    cyc();
    check("lid_err_state", int'(state_out), 8);
    check("lid_err_code", int'(error_code), 1);
    check("lid_alarm", int'(alarm), 1);
    cyc(); cyc();
    check("err_drain_wet", int'(drain_on), 1);
    water_empty = 1'b1;
    cyc();
    check("err_drain_dry", int'(drain_on), 0);
    start = 1'b1; lid_closed = 1'b1;
    cyc();
    start = 1'b0;
    check("err_clear_state", int'(state_out), 0);
    check("err_clear_code", int'(error_code), 0);

    // Fill watchdog with ticks on alternate cycles.
    begin_cycle(2'd0, 2'd0);
    water_full = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && state_out == 4'd1; i++) begin
      tick = 1'(i % 2);
      if (tick) n++;
      cyc();
    end
    check("fill_timeout_ticks", n, FILL_TO);
    check("fill_timeout_code", int'(error_code), 3);
    tick = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("fill_timeout_clear", int'(state_out), 0);

    // Abort during SPIN.
    e0 = eoc_cnt;
    begin_cycle(2'd0, 2'd0);
    wait_state(5, 60, "abort_reach_spin");
    abort = 1'b1; water_empty = 1'b0;
    cyc();
    abort = 1'b0;
    check("abort_to_drain", int'(state_out), 3);
    cyc(); cyc();
    water_empty = 1'b1;
    cyc();
    check("abort_to_idle", int'(state_out), 0);
    check("abort_no_eoc", eoc_cnt - e0, 0);

    // Reset asserted mid-SPIN.
    begin_cycle(2'd3, 2'd3);
    wait_state(5, 80, "reset_reach_spin");
    reset = 1'b1;
    #1;
    check("midspin_reset_outputs", int'(act_vec()), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_st = 0;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      tick               = 1'($urandom_range(0, 1));
      start              = ($urandom_range(0, 9) == 0);
      pause              = ($urandom_range(0, 11) == 0);
      abort              = ($urandom_range(0, 59) == 0);
      lid_closed         = ($urandom_range(0, 49) != 0);
      load_balanced      = ($urandom_range(0, 59) != 0);
      water_full         = ($urandom_range(0, 3) == 0);
      water_empty        = ($urandom_range(0, 3) == 0);
      cycle_select       = 2'($urandom_range(0, 3));
      water_level_select = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
